adder_arbiter: RTL and testbench

Round-robin arbiter that shares one SIZE-bit ripple-carry adder between two requesters. Each requester presents an operand pair and carry-in on a valid/ready handshake. The block grants one request per cycle, drives the shared adder, and registers sum, carry-out, overflow and requester ID into a single-entry response stage with backpressure. It sits between the two arithmetic clients and the adder datapath.

---
 rtl/adder_arb_pkg.sv | 18 +
 rtl/ripple_carry_adder.sv | 37 +++
 rtl/rr_arb2.sv | 28 ++
 rtl/adder_arbiter.sv | 141 ++++++++++++++
 tb/tb_adder_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types for the adder arbiter: response-stage state, requester ID, stats width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_arb_pkg;

    // Single-entry response stage occupancy.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // Requester identifier: 0 or 1.
    typedef logic req_id_t;

    // Width of the optional per-requester accept counters.
    localparam int STATS_W = 16;

endpackage

// File: rtl/ripple_carry_adder.sv
// SIZE-bit ripple-carry adder with carry-in, carry-out and two's-complement overflow.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   a, b      in   operands
//   cin       in   carry into bit 0
//   s         out  sum
//   cout      out  carry out of bit SIZE-1
//   overflow  out  carry[SIZE] ^ carry[SIZE-1]
module ripple_carry_adder #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            cout,
    output logic            overflow
);

    logic [SIZE:0] carry;

    assign carry[0] = cin;

    genvar i;
    generate
        for (i = 0; i < SIZE; i++) begin : g_fa
            assign s[i]       = a[i] ^ b[i] ^ carry[i];
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    endgenerate

    assign cout     = carry[SIZE];
    assign overflow = carry[SIZE] ^ carry[SIZE-1];

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: the requester that did not win last goes first on contention.
// Latency: combinational.
// Backpressure: enable low suppresses every grant (used for a full response slot and reset).
//
// Ports:
//   valid0, valid1  in   request lines
//   last_grant      in   ID of the previous winner
//   enable          in   grants allowed this cycle
//   gnt0, gnt1      out  one-hot (or zero) grant
//   gnt_id          out  ID of the granted requester, 0 when nobody is granted
module rr_arb2
    import adder_arb_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    input  logic    enable,
    output logic    gnt0,
    output logic    gnt1,
    output req_id_t gnt_id
);

    // A lone requester always wins; on contention the previous loser wins.
    assign gnt0   = enable && valid0 && (!valid1 || (last_grant == 1'b1));
    assign gnt1   = enable && valid1 && (!valid0 || (last_grant == 1'b0));
    assign gnt_id = gnt1;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin share of one SIZE-bit adder between two valid/ready requesters, result registered.
// Latency: accept in cycle N, rsp_valid high in cycle N+1; one op per cycle while rsp_ready is high.
// Backpressure: a full response slot with rsp_ready low holds the result and drops both readies.
//
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   reqN_valid/ready/a/b/cin (N=0,1)   requester handshake, operands and carry-in
//   rsp_valid/ready                    response handshake
//   rsp_id, rsp_s, rsp_carryout,       issuing requester, sum, carry-out,
//   rsp_overflow                       signed overflow
//   grant_cnt0, grant_cnt1             saturating accept counters, present only when
//                                      ADDER_ARB_STATS_EN is defined
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [SIZE-1:0] req0_a,
    input  logic [SIZE-1:0] req0_b,
    input  logic            req0_cin,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [SIZE-1:0] req1_a,
    input  logic [SIZE-1:0] req1_b,
    input  logic            req1_cin,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [SIZE-1:0] rsp_s,
    output logic            rsp_carryout,
    output logic            rsp_overflow
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1
`endif
);

    rsp_state_e state_q;
    rsp_state_e state_d;
    req_id_t    last_grant_q;

    logic       slot_free;
    logic       gnt0;
    logic       gnt1;
    req_id_t    gnt_id;
    logic       accept;

    logic [SIZE-1:0] add_a;
    logic [SIZE-1:0] add_b;
    logic            add_cin;
    logic [SIZE-1:0] add_s;
    logic            add_cout;
    logic            add_ovf;

    assign rsp_valid = (state_q == RSP_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // rst_n gates the arbiter so no accept can happen while reset is held.
    rr_arb2 u_rr_arb2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .enable     (slot_free && rst_n),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .gnt_id     (gnt_id)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 || gnt1;

    // gnt_id is 0 with no grant, so the adder idles on requester 0's operands.
    assign add_a   = gnt_id ? req1_a   : req0_a;
    assign add_b   = gnt_id ? req1_b   : req0_b;
    assign add_cin = gnt_id ? req1_cin : req0_cin;

    ripple_carry_adder #(
        .SIZE (SIZE)
    ) u_adder (
        .a        (add_a),
        .b        (add_b),
        .cin      (add_cin),
        .s        (add_s),
        .cout     (add_cout),
        .overflow (add_ovf)
    );

    // Response-stage occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (accept)                  state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !accept)    state_d = RSP_EMPTY;
            default:                                state_d = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RSP_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data fields only move on accept; a consume alone leaves them holding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_s        <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_id       <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first contention
        end else if (accept) begin
            rsp_s        <= add_s;
            rsp_carryout <= add_cout;
            rsp_overflow <= add_ovf;
            rsp_id       <= gnt_id;
            last_grant_q <= gnt_id;
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0 && (grant_cnt0 != {STATS_W{1'b1}})) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (gnt1 && (grant_cnt1 != {STATS_W{1'b1}})) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed scenarios plus random traffic vs a reference model.
// Latency: n/a.
// Backpressure: randomised rsp_ready; requesters hold operands while pending.
module tb_adder_arbiter;

    localparam int SIZE = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [SIZE-1:0] req0_a, req0_b, req1_a, req1_b;
    logic            req0_cin, req1_cin;
    logic            rsp_valid, rsp_ready;
    logic            rsp_id;
    logic [SIZE-1:0] rsp_s;
    logic            rsp_carryout, rsp_overflow;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    adder_arbiter #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_cin     (req0_cin),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_cin     (req1_cin),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_s        (rsp_s),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_cnt0   (grant_cnt0),
        .grant_cnt1   (grant_cnt1)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: transaction-level view of the response slot.
    bit              m_known = 1'b0;
    bit              m_valid;
    logic [SIZE-1:0] m_s;
    bit              m_co, m_ov, m_id, m_last;
    int              m_cnt0, m_cnt1;
    bit              m_acc0, m_acc1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which requester should win: -1 none, 0 or 1.
    function automatic int pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        bit sf;
        g  = pick(req0_valid, req1_valid, m_last);
        sf = !m_valid || rsp_ready;
        chk("req0_ready", req0_ready, (rst_n && m_known && sf && g == 0) ? 1 : 0);
        chk("req1_ready", req1_ready, (rst_n && m_known && sf && g == 1) ? 1 : 0);
        if (m_known) begin
            chk("rsp_valid", rsp_valid, m_valid);
            chk("rsp_s", rsp_s, m_s);
            chk("rsp_carryout", rsp_carryout, m_co);
            chk("rsp_overflow", rsp_overflow, m_ov);
            chk("rsp_id", rsp_id, m_id);
`ifdef ADDER_ARB_STATS_EN
            chk("grant_cnt0", grant_cnt0, m_cnt0);
            chk("grant_cnt1", grant_cnt1, m_cnt1);
`endif
        end
    endtask

    task automatic update_model();
        int g;
        logic [SIZE:0]   full;
        logic [SIZE-1:0] a, b;
        logic            c;
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        if (!rst_n) begin
            m_known = 1'b1; m_valid = 1'b0; m_s = '0; m_co = 1'b0; m_ov = 1'b0;
            m_id = 1'b0; m_last = 1'b1; m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_known) begin
            g = pick(req0_valid, req1_valid, m_last);
            if ((!m_valid || rsp_ready) && g >= 0) begin
                a = (g == 1) ? req1_a : req0_a;
                b = (g == 1) ? req1_b : req0_b;
                c = (g == 1) ? req1_cin : req0_cin;
                full = {1'b0, a} + {1'b0, b} + {{SIZE{1'b0}}, c};
                m_s  = full[SIZE-1:0];
                m_co = full[SIZE];
                // Signed overflow: like-signed operands give a result of the other sign.
                m_ov = (a[SIZE-1] == b[SIZE-1]) && (m_s[SIZE-1] != a[SIZE-1]);
                m_id = (g == 1);
                m_last = (g == 1);
                m_valid = 1'b1;
                if (g == 0) begin m_acc0 = 1'b1; if (m_cnt0 < 65535) m_cnt0++; end
                else        begin m_acc1 = 1'b1; if (m_cnt1 < 65535) m_cnt1++; end
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: check at the falling edge, advance the model on the rising edge, return 1 later.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        update_model();
        #1;
    endtask

    function automatic logic [SIZE-1:0] rnd();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return {1'b0, {(SIZE-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    task automatic new_ops(input int n);
        if (n == 0) begin req0_a = rnd(); req0_b = rnd(); req0_cin = $urandom_range(0, 1); end
        else        begin req1_a = rnd(); req1_b = rnd(); req1_cin = $urandom_range(0, 1); end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state.
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_s", rsp_s, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_flags", {rsp_carryout, rsp_overflow}, 0);

        // Single op on requester 0: positive overflow.
        req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'h0000_0001; req0_cin = 1'b0;
        step();
        req0_valid = 1'b0;
        chk("single_valid", rsp_valid, 1);
        chk("single_s", rsp_s, 32'h8000_0000);
        chk("single_co", rsp_carryout, 0);
        chk("single_ov", rsp_overflow, 1);
        chk("single_id", rsp_id, 0);

        // Carry-in wrap on requester 1.
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_0000; req1_cin = 1'b1;
        step();
        req1_valid = 1'b0;
        chk("wrap_s", rsp_s, 32'h0000_0000);
        chk("wrap_co", rsp_carryout, 1);
        chk("wrap_ov", rsp_overflow, 0);
        chk("wrap_id", rsp_id, 1);
        step();
        chk("drain_valid", rsp_valid, 0);

        // Contention from reset: 0,1,0,1.
        do_reset();
        new_ops(0); new_ops(1);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("contention_order", rsp_id, i % 2);
            if (m_acc0) new_ops(0);
            if (m_acc1) new_ops(1);
        end

        // Backpressure: three stalled cycles, then the other requester wins.
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_readies", {req0_ready, req1_ready}, 0);
            chk("stall_valid", rsp_valid, 1);
        end
        rsp_ready = 1'b1;
        step();
        chk("after_stall_id", rsp_id, 0);
        if (m_acc0) new_ops(0);

        // Reset mid-flight with a held result.
        rsp_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", {rsp_s, rsp_carryout, rsp_overflow, rsp_id}, 0);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        step();
        chk("midrst_first_grant", rsp_id, 0);
        if (m_acc0) new_ops(0);
        if (m_acc1) new_ops(1);

        // Random traffic; pending requests keep their operands.
        for (int i = 0; i < 400; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (!(req0_valid && !m_acc0)) begin req0_valid = $urandom_range(0, 1); new_ops(0); end
            if (!(req1_valid && !m_acc1)) begin req1_valid = $urandom_range(0, 1); new_ops(1); end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step();

`ifdef ADDER_ARB_STATS_EN
        // Counters: 5 accepts on req0, 3 on req1.
        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin new_ops(0); step(); end
        req0_valid = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin new_ops(1); step(); end
        req1_valid = 1'b0;
        step();
        chk("stats_cnt0", grant_cnt0, 5);
        chk("stats_cnt1", grant_cnt1, 3);

        // Saturation: drive req0 past 0xFFFF accepts.
        req0_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin new_ops(0); step(); end
        req0_valid = 1'b0;
        step();
        chk("stats_saturate", grant_cnt0, 16'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
